// File: rtl/multdiv_pkg.sv
// Shared types for the multiply/divide sequencer: state encodings, width and iteration bound.
// MULTDIV_DIV_EN selects the full divide state set; without it only a one-cycle reject state remains.
package multdiv_pkg;

  localparam int         WIDTH     = 32;
  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MUL_RUN    = 3'd1,
`ifdef MULTDIV_DIV_EN
    DIV_NEGA   = 3'd2,
    DIV_NEGB   = 3'd3,
    DIV_RUN    = 3'd4,
    DIV_FIX    = 3'd5,
`else
    // Keeps the divide-reject ready pulse two edges after start.
    DIV_REJECT = 3'd2,
`endif
    DONE       = 3'd6
  } state_t;

  // The 64-bit product fits in 32 bits only if the high word is a sign extension of the low word.
  function automatic logic mul_ovf(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    return hi != {WIDTH{lo[WIDTH-1]}};
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Execute-stage port bundle of the sequencer: start/operands, result/ready and the shared-adder port pair.
interface multdiv_if;
  import multdiv_pkg::*;

  // Handshake: ctrl_MULT/ctrl_DIV are start pulses accepted only in IDLE (MULT wins if both are high);
  // busy is high from the cycle after acceptance through the ready cycle; data_resultRDY is a one-cycle
  // pulse that qualifies data_result/data_exception, which then hold until the next completion.
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_cin;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_cout;
  state_t           dbg_state;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, adder_sum, adder_cout,
    output data_result, data_exception, data_resultRDY, busy, adder_a, adder_b, adder_cin, dbg_state
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, adder_sum, adder_cout,
    input  data_result, data_exception, data_resultRDY, busy, adder_a, adder_b, adder_cin, dbg_state
  );

endinterface

// File: rtl/multdiv_fsm.sv
// Sequencer control: state register, 5-bit iteration counter and start arbitration.
// MULTDIV_DIV_EN enables the divide states and the divide-by-zero early exit.
module multdiv_fsm
  import multdiv_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   ctrl_mult,
  input  logic   ctrl_div,
`ifdef MULTDIV_DIV_EN
  input  logic   div_zero,
`endif
  output state_t state,
  output logic   start_mul,
  output logic   start_div
);

  logic [4:0] cnt;

  assign start_mul = (state == IDLE) && ctrl_mult;
  assign start_div = (state == IDLE) && ctrl_div && !ctrl_mult;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_mul) state <= MUL_RUN;
`ifdef MULTDIV_DIV_EN
          else if (start_div) state <= DIV_NEGA;
`else
          else if (start_div) state <= DIV_REJECT;
`endif
        end
        MUL_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == ITER_LAST) state <= DONE;
        end
`ifdef MULTDIV_DIV_EN
        DIV_NEGA: state <= div_zero ? DONE : DIV_NEGB;
        DIV_NEGB: begin
          cnt   <= '0;
          state <= DIV_RUN;
        end
        DIV_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == ITER_LAST) state <= DIV_FIX;
        end
        DIV_FIX: state <= DONE;
`else
        DIV_REJECT: state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Signed multiply (radix-2 Booth) / divide (restoring on magnitudes) sequencer on a borrowed 32-bit adder.
// Define MULTDIV_DIV_EN for the divide datapath; otherwise a divide start returns result 0 with exception set.
module multdiv_ctrl
  import multdiv_pkg::*;
(
  input logic      clock,
  input logic      reset_n,
  multdiv_if.slave bus
);

  state_t      state;
  logic        start_mul;
  logic        start_div;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [31:0] m;
  logic        q_bit;
  logic        is_mul;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic        mul_sign;

`ifdef MULTDIV_DIV_EN
  // Remainder stays below the divisor magnitude (at most 2^31), so 31 bits suffice.
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [30:0] rem;
  logic        neg_q;
  logic        div_exc;
  logic [31:0] rem_sh;

  assign rem_sh = {rem, quo[31]};
`endif

  multdiv_fsm u_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .ctrl_mult (bus.ctrl_MULT),
    .ctrl_div  (bus.ctrl_DIV),
`ifdef MULTDIV_DIV_EN
    .div_zero  (dvs == '0),
`endif
    .state     (state),
    .start_mul (start_mul),
    .start_div (start_div)
  );

  assign bus.dbg_state = state;
  assign bus.adder_a   = add_a;
  assign bus.adder_b   = add_b;
  assign bus.adder_cin = add_cin;

  // True sign of the 33-bit partial sum, so the arithmetic shift never loses an overflowing carry.
  assign mul_sign = add_a[31] ^ add_b[31] ^ bus.adder_cout;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL_RUN: begin
        add_a = p_hi;
        case ({p_lo[0], q_bit})
          2'b01:   add_b = m;
          2'b10: begin
            add_b   = ~m;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
`ifdef MULTDIV_DIV_EN
      DIV_NEGA, DIV_FIX: begin
        add_a   = ~quo;
        add_cin = 1'b1;
      end
      DIV_NEGB: begin
        add_a   = ~dvs;
        add_cin = 1'b1;
      end
      DIV_RUN: begin
        add_a   = rem_sh;
        add_b   = ~dvs;
        add_cin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      p_hi               <= '0;
      p_lo               <= '0;
      m                  <= '0;
      q_bit              <= 1'b0;
      is_mul             <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
`ifdef MULTDIV_DIV_EN
      quo                <= '0;
      dvs                <= '0;
      rem                <= '0;
      neg_q              <= 1'b0;
      div_exc            <= 1'b0;
`endif
    end else begin
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start_mul) begin
            is_mul <= 1'b1;
            p_hi   <= '0;
            p_lo   <= bus.data_operandB;
            q_bit  <= 1'b0;
            m      <= bus.data_operandA;
          end else if (start_div) begin
            is_mul <= 1'b0;
`ifdef MULTDIV_DIV_EN
            quo     <= bus.data_operandA;
            dvs     <= bus.data_operandB;
            neg_q   <= bus.data_operandA[31] ^ bus.data_operandB[31];
            div_exc <= 1'b0;
`endif
          end
        end
        MUL_RUN: begin
          p_hi  <= {mul_sign, bus.adder_sum[31:1]};
          p_lo  <= {bus.adder_sum[0], p_lo[31:1]};
          q_bit <= p_lo[0];
        end
`ifdef MULTDIV_DIV_EN
        DIV_NEGA: begin
          rem <= '0;
          if (dvs == '0) begin
            quo     <= '0;
            div_exc <= 1'b1;
          end else if (quo[31]) begin
            quo <= bus.adder_sum;
          end
        end
        DIV_NEGB: begin
          rem <= '0;
          if (dvs[31]) dvs <= bus.adder_sum;
        end
        DIV_RUN: begin
          rem <= bus.adder_cout ? bus.adder_sum[30:0] : rem_sh[30:0];
          quo <= {quo[30:0], bus.adder_cout};
        end
        DIV_FIX: begin
          // A magnitude quotient of 2^31 is only representable when the result is negative.
          div_exc <= ~neg_q & quo[31];
          if (neg_q) quo <= bus.adder_sum;
        end
`endif
        DONE: begin
          bus.data_resultRDY <= 1'b1;
          if (is_mul) begin
            bus.data_result    <= p_lo;
            bus.data_exception <= mul_ovf(p_hi, p_lo);
          end else begin
`ifdef MULTDIV_DIV_EN
            bus.data_result    <= quo;
            bus.data_exception <= div_exc;
`else
            bus.data_result    <= '0;
            bus.data_exception <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: models the shared adder, drives starts and checks results and timing.
// Divide expectations follow MULTDIV_DIV_EN; without it every divide is a one-cycle reject.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];

  multdiv_if bus ();

  multdiv_ctrl dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // The processor's adder, owned by the parent.
  assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {32'd0, bus.adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Presents a start for one cycle; returns at the falling edge after the sampling edge E0.
  task automatic drive_start(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = dv;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // Observes budget+1 falling edges (k = 0 is the one after E0); optionally pulses a start at step pulse_k.
  task automatic collect(input int budget, input int pulse_k, input logic pulse_mul, input logic pulse_div,
                         output int lat, output int busy_n, output int rdy_n,
                         output logic [31:0] res, output logic exc);
    lat = 0; busy_n = 0; rdy_n = 0; res = '0; exc = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      bus.ctrl_MULT = (k == pulse_k) && pulse_mul;
      bus.ctrl_DIV  = (k == pulse_k) && pulse_div;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.data_resultRDY === 1'b1) begin
        rdy_n++;
        if (lat == 0) begin
          lat = k;
          res = bus.data_result;
          exc = bus.data_exception;
        end
      end
    end
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", bus.data_result); end
    n_tests++; if (bus.data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", bus.data_exception); end
    n_tests++; if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", bus.data_resultRDY); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.adder_a !== 32'd0) begin n_fail++; $display("FAIL reset_adder_a got %h want 00000000", bus.adder_a); end
    n_tests++; if (bus.adder_b !== 32'd0) begin n_fail++; $display("FAIL reset_adder_b got %h want 00000000", bus.adder_b); end
    n_tests++; if (bus.adder_cin !== 1'b0) begin n_fail++; $display("FAIL reset_adder_cin got %b want 0", bus.adder_cin); end
    n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", bus.dbg_state, IDLE); end
  endtask

  task automatic test_mult();
    logic [31:0] ta[7];
    logic [31:0] tb_v[7];
    logic [31:0] tr[7];
    logic        te[7];
    logic [31:0] res, exp;
    logic        exc;
    int          lat, bsy, rdy;
    ta   = '{32'd7,        32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    tb_v = '{32'hFFFFFFFD, 32'h00010000, 32'd1,        32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    tr   = '{32'hFFFFFFEB, 32'h00000000, 32'h80000000, 32'h00000001, 32'h00000001, 32'h00000000, 32'h80000000};
    te   = '{1'b0,         1'b1,         1'b0,         1'b0,         1'b1,         1'b1,         1'b1};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tr[i]);
      drive_start(1'b1, 1'b0, ta[i], tb_v[i]);
      collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
      exp = exp_q.pop_front();
      n_tests++; if (res !== exp) begin n_fail++; $display("FAIL mul_res[%0d] got %h want %h", i, res, exp); end
      n_tests++; if (exc !== te[i]) begin n_fail++; $display("FAIL mul_exc[%0d] got %b want %b", i, exc, te[i]); end
      n_tests++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat); end
      n_tests++; if (bsy != 33) begin n_fail++; $display("FAIL mul_busy_cycles[%0d] got %0d want 33", i, bsy); end
      n_tests++; if (rdy != 1) begin n_fail++; $display("FAIL mul_rdy_pulses[%0d] got %0d want 1", i, rdy); end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta[8];
    logic [31:0] tb_v[8];
    logic [31:0] tr[8];
    logic        te[8];
    int          tl;
    int          tbsy;
    logic [31:0] res, exp;
    logic        exc;
    int          lat, bsy, rdy;
    ta   = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd7,        32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    tb_v = '{32'd2,        32'hFFFFFFFF, 32'd7,   32'hFFFFFFF9, 32'hFFFFFF9C, 32'd1,        32'h80000000, 32'h80000000};
`ifdef MULTDIV_DIV_EN
    tr   = '{32'hFFFFFFFD, 32'h80000000, 32'd14,  32'd14,       32'd0,        32'h80000000, 32'd0,        32'd1};
    te   = '{1'b0,         1'b1,         1'b0,    1'b0,         1'b0,         1'b0,         1'b0,         1'b0};
    tl   = 36;
    tbsy = 36;
`else
    tr   = '{8{32'd0}};
    te   = '{8{1'b1}};
    tl   = 2;
    tbsy = 2;
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tr[i]);
      drive_start(1'b0, 1'b1, ta[i], tb_v[i]);
      collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
      exp = exp_q.pop_front();
      n_tests++; if (res !== exp) begin n_fail++; $display("FAIL div_res[%0d] got %h want %h", i, res, exp); end
      n_tests++; if (exc !== te[i]) begin n_fail++; $display("FAIL div_exc[%0d] got %b want %b", i, exc, te[i]); end
      n_tests++; if (lat != tl) begin n_fail++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, tl); end
      n_tests++; if (bsy != tbsy) begin n_fail++; $display("FAIL div_busy_cycles[%0d] got %0d want %0d", i, bsy, tbsy); end
      n_tests++; if (rdy != 1) begin n_fail++; $display("FAIL div_rdy_pulses[%0d] got %0d want 1", i, rdy); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    logic        exc;
    int          lat, bsy, rdy;
    drive_start(1'b0, 1'b1, 32'd5, 32'd0);
    collect(10, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'd0) begin n_fail++; $display("FAIL divzero_res got %h want 00000000", res); end
    n_tests++; if (exc !== 1'b1) begin n_fail++; $display("FAIL divzero_exc got %b want 1", exc); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL divzero_latency got %0d want 2", lat); end
    n_tests++; if (bsy != 2) begin n_fail++; $display("FAIL divzero_busy_cycles got %0d want 2", bsy); end
  endtask

  task automatic test_both_starts();
    logic [31:0] res;
    logic        exc;
    int          lat, bsy, rdy;
    drive_start(1'b1, 1'b1, 32'd6, 32'd7);
    collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'd42) begin n_fail++; $display("FAIL both_res got %h want 0000002a", res); end
    n_tests++; if (exc !== 1'b0) begin n_fail++; $display("FAIL both_exc got %b want 0", exc); end
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL both_latency got %0d want 33", lat); end
  endtask

  task automatic test_ignore_mid();
    logic [31:0] res;
    logic        exc;
    int          lat, bsy, rdy;
    drive_start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    collect(40, 5, 1'b0, 1'b1, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL ignore_res got %h want ffffffeb", res); end
    n_tests++; if (rdy != 1) begin n_fail++; $display("FAIL ignore_rdy_pulses got %0d want 1", rdy); end
    n_tests++; if (bsy != 33) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 33", bsy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic        exc;
    int          lat, bsy, rdy;
    // Start presented while in DONE must be dropped.
    drive_start(1'b1, 1'b0, 32'd9, 32'd11);
    collect(40, 32, 1'b1, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'd99) begin n_fail++; $display("FAIL b2b_res got %h want 00000063", res); end
    n_tests++; if (rdy != 1) begin n_fail++; $display("FAIL b2b_rdy_pulses got %0d want 1", rdy); end
    n_tests++; if (bsy != 33) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 33", bsy); end
    // Start in the cycle right after DONE is accepted.
    drive_start(1'b1, 1'b0, 32'hFFFFFFF6, 32'd10);
    collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'hFFFFFF9C) begin n_fail++; $display("FAIL b2b_second_res got %h want ffffff9c", res); end
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        exc;
    int          lat, bsy, rdy;
    drive_start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state got %0d want %0d", bus.dbg_state, IDLE); end
    n_tests++; if (bus.data_result !== 32'd0) begin n_fail++; $display("FAIL midrst_result got %h want 00000000", bus.data_result); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy got %b want 0", bus.data_resultRDY); end
    n_tests++; if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 65'd0) begin n_fail++; $display("FAIL midrst_adder got %h %h %b want all zero", bus.adder_a, bus.adder_b, bus.adder_cin); end
    rst_n = 1'b1;
    collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (rdy != 0) begin n_fail++; $display("FAIL midrst_rdy_pulses got %0d want 0", rdy); end
    n_tests++; if (bsy != 0) begin n_fail++; $display("FAIL midrst_busy_cycles got %0d want 0", bsy); end
    drive_start(1'b1, 1'b0, 32'd3, 32'd4);
    collect(40, -1, 1'b0, 1'b0, lat, bsy, rdy, res, exc);
    n_tests++; if (res !== 32'd12) begin n_fail++; $display("FAIL midrst_next_res got %h want 0000000c", res); end
    n_tests++; if (lat != 33) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 33", lat); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n             = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_mult();
    test_div();
    test_div_zero();
    test_both_starts();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Multi-cycle signed multiply/divide sequencer for the execute stage. It owns no adder of its own: it time-shares the processor's single 32-bit carry-lookahead adder through an operand/result port pair, and drives it once per cycle. Multiply is radix-2 Booth; divide is restoring on magnitudes with sign fix-up. The block returns a 32-bit result plus an exception flag, and signals completion with a one-cycle ready pulse.

## Interface
- No parameters; width fixed at 32.
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- ctrl_MULT  in  1  start-multiply pulse (sampled in IDLE only)
- ctrl_DIV  in  1  start-divide pulse (sampled in IDLE only)
- data_operandA  in  32  multiplicand / dividend, signed, sampled with start
- data_operandB  in  32  multiplier / divisor, signed, sampled with start
- data_result  out  32  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero, valid with ready
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start through the ready cycle
- adder_a, adder_b  out  32  shared-adder operands
- adder_cin  out  1  shared-adder carry-in
- adder_sum  in  32  shared-adder sum, combinational, same cycle
- adder_cout  in  1  shared-adder carry-out

## Operation
- States: IDLE, MUL_RUN, DIV_NEGA, DIV_NEGB, DIV_RUN, DIV_FIX, DONE; 5-bit iteration counter.
- Start rules:
  - In IDLE, ctrl_MULT goes to MUL_RUN and ctrl_DIV goes to DIV_NEGA.
  - If both are high, MULT wins.
  - Starts outside IDLE are ignored.
- Multiply setup: P_hi=0, P_lo=B, q=0, M=A.
- Multiply iteration, selected by {P_lo[0],q}:
  - 01: adder_b=M, cin=0.
  - 10: adder_b=~M, cin=1.
  - 00/11: adder_b=0, cin=0.
  - adder_a=P_hi in every case.
  - Shift in sign s = adder_a[31]^adder_b[31]^adder_cout (true 33-bit sign).
  - {P_hi,P_lo,q} <= {s, adder_sum, P_lo}.
- Multiply finish: 32 iterations, then DONE. result=P_lo; exception = (P_hi != {32{P_lo[31]}}).
- Divide by zero: in DIV_NEGA, B==0 goes directly to DONE with result 0 and exception 1.
- Divide setup:
  - DIV_NEGA: adder computes ~A+1; store |A| in Q.
  - DIV_NEGB: same for |B| into D.
  - R=0.
- Divide iteration:
  - Shift {R,Q} left by 1.
  - adder_a = shifted R, adder_b = ~D, cin=1.
  - If adder_cout=1: R=adder_sum and Q[0]=1. Otherwise restore (R unchanged) and Q[0]=0.
- Divide fix-up:
  - DIV_FIX: if A[31]^B[31], result = ~Q+1 via adder; otherwise result = Q.
  - Truncation is toward zero; the remainder is discarded.
  - exception = 1 only for -2^31 / -1 (result 0x80000000).
- Adder port values: IDLE and DONE drive adder_a=0, adder_b=0, cin=0.
- Output reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, all adder outputs 0.
- Output hold: data_result and data_exception hold until the next completion.
- Reset mid-operation: return to IDLE on the next edge, with no ready pulse and the result cleared.

## Timing
- Start sampled at edge E0.
- Multiply: MUL_RUN covers E0+1..E0+32; data_resultRDY is high in the cycle following edge E0+33.
- Divide: DIV_NEGA (1), DIV_NEGB (1), DIV_RUN (32) and DIV_FIX (1); data_resultRDY is high after edge E0+36.
- Divide by zero: data_resultRDY is high after edge E0+2.
- DONE lasts exactly one cycle, then IDLE; a new start is accepted in the cycle after DONE.
- Back-to-back: a start asserted during DONE is ignored.

## Configuration
- MULTDIV_DIV_EN defined: full divide path as above.
- MULTDIV_DIV_EN undefined:
  - Div states and registers D and R are removed.
  - ctrl_DIV in IDLE goes to DONE the next cycle with result 0 and exception 1 (ready after E0+2).
  - Multiply is unchanged.

## Structure
- multdiv_pkg: state encodings, ITER_LAST=31, WIDTH=32.
- One sub-module, multdiv_fsm: state register, counter and start arbitration.
- Datapath registers and adder-port muxing stay in multdiv_ctrl.
- The adder is instantiated by the parent and connected via the adder_* ports.

## Test plan
- MULT A=7, B=-3 -> result 0xFFFFFFEB, exception 0, ready exactly after E0+33, busy high 33 cycles.
- MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; MULT A=0x80000000, B=1 -> 0x80000000, exception 0.
- DIV A=-7, B=2 -> result 0xFFFFFFFD, exception 0, ready after E0+36; DIV A=0x80000000, B=-1 -> 0x80000000, exception 1.
- DIV A=5, B=0 -> result 0, exception 1, ready after E0+2.
- ctrl_MULT and ctrl_DIV together -> multiply performed; ctrl_DIV pulsed mid-multiply -> ignored, single ready pulse.
- reset_n low at E0+10 of a multiply -> IDLE next edge, all outputs 0, no ready pulse; next MULT 3×4 -> 12.
